// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM states.
package mdu_pkg;

  localparam int unsigned OP_W            = 3;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MSUB  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Encodings 6 and 7 are reserved and never launch an operation.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: computes the HI/LO update for a latched operation.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo,
  output logic             o_write_en
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [PW-1:0]    w_sa, w_sb, w_ua, w_ub;
  logic [PW-1:0]    w_sprod, w_uprod, w_acc, w_madd, w_msub;
  logic             w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_b_mag_safe, w_b_safe;
  logic [WIDTH-1:0] w_mag_q, w_mag_r, w_sq, w_sr, w_uq, w_ur;

  // Low 2*WIDTH bits of the extended-operand product equal the exact signed product.
  assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_ua    = {{WIDTH{1'b0}}, i_a};
  assign w_ub    = {{WIDTH{1'b0}}, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = w_ua * w_ub;
  assign w_acc   = {i_hi, i_lo};
  assign w_madd  = w_acc + w_sprod;
  assign w_msub  = w_acc - w_sprod;

  // Signed divide via magnitudes: truncates toward zero and makes MIN / -1 fall out as MIN rem 0.
  assign w_b_zero     = (i_b == '0);
  assign w_a_neg      = i_a[WIDTH-1];
  assign w_b_neg      = i_b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? (-i_a) : i_a;
  assign w_b_mag      = w_b_neg ? (-i_b) : i_b;
  assign w_b_mag_safe = w_b_zero ? ONE : w_b_mag;
  assign w_b_safe     = w_b_zero ? ONE : i_b;
  assign w_mag_q      = w_a_mag / w_b_mag_safe;
  assign w_mag_r      = w_a_mag % w_b_mag_safe;
  assign w_sq         = (w_a_neg ^ w_b_neg) ? (-w_mag_q) : w_mag_q;
  assign w_sr         = w_a_neg ? (-w_mag_r) : w_mag_r;
  assign w_uq         = i_a / w_b_safe;
  assign w_ur         = i_a % w_b_safe;

  always_comb begin
    o_next_hi  = i_hi;
    o_next_lo  = i_lo;
    o_write_en = 1'b1;
    case (i_op)
      MD_MULT:  {o_next_hi, o_next_lo} = w_sprod;
      MD_MULTU: {o_next_hi, o_next_lo} = w_uprod;
      MD_MADD:  {o_next_hi, o_next_lo} = w_madd;
      MD_MSUB:  {o_next_hi, o_next_lo} = w_msub;
      MD_DIV: begin
        o_next_hi  = w_sr;
        o_next_lo  = w_sq;
        o_write_en = !w_b_zero;
      end
      MD_DIVU: begin
        o_next_hi  = w_ur;
        o_next_lo  = w_uq;
        o_write_en = !w_b_zero;
      end
      default: o_write_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_pipelined.sv
// EX-stage multiply/divide unit: owns HI/LO, models latency with a busy counter.
module mdu_pipelined
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  mdu_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;

  logic             w_accept, w_commit, w_wen;
  logic [CW-1:0]    w_load;
  logic [WIDTH-1:0] w_next_hi, w_next_lo;

  assign w_accept = start && op_is_valid(op) && (r_state == ST_IDLE);
  assign w_load   = op_is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  assign w_commit = (r_state == ST_RUN) && (r_cnt == CW'(1));

  mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_next_hi (w_next_hi),
    .o_next_lo (w_next_lo),
    .o_write_en(w_wen)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= w_load;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Direct writes only when idle and no start is presented; start wins even if its op is invalid.
      if (w_commit) begin
        if (w_wen) begin
          r_hi <= w_next_hi;
          r_lo <= w_next_lo;
        end
      end else if ((r_state == ST_IDLE) && !start) begin
        if (hi_we) r_hi <= wd;
        if (lo_we) r_lo <= wd;
      end
    end
  end

  assign busy = w_accept || (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mdu_pipelined.md
Name: mdu_pipelined

Overview:
- Parametrised multiply/divide unit for the next pipelined MIPS core generation; sits in the EX stage beside the ALU.
- Owns the HI/LO register pair and models multi-cycle latency with a busy counter, so the hazard controller can stall mfhi/mflo/md instructions.
- Supports signed/unsigned multiply, signed/unsigned divide, and signed multiply-accumulate/subtract (madd/msub).
- Adds direct HI/LO writes (mthi/mtlo).

Parameters:
- WIDTH, 32: operand and HI/LO width; the product is 2*WIDTH.
- MULT_CYCLES, 5: busy cycles for mult/multu/madd/msub; must be >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation `op` this cycle.
- op  in  3  operation code (see package).
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- hi_we  in  1  write `wd` into HI (mthi).
- lo_we  in  1  write `wd` into LO (mtlo).
- wd  in  WIDTH  write data for mthi/mtlo.
- busy  out  1  operation in flight; also high in the cycle start is accepted (start_q).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - hi=0, lo=0, busy=0, counter=0, operand latches cleared.
  - Reset cancels any in-flight operation; no HI/LO update from it.
- State machine has two states, IDLE and RUN.
- IDLE:
  - When start=1 and op is valid: latch a, b, op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - An invalid op with start=1 is ignored and the unit stays IDLE.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1, the result is committed to HI/LO and the unit returns to IDLE.
- Timing: start accepted at cycle t gives busy=1 in cycles t+1..t+N (N = latency). New HI/LO are visible in cycle t+N+1, when busy=0.
- busy output = start (valid op, IDLE) OR (state==RUN). The ID stage therefore sees the stall in the same cycle as issue.
- start while RUN is ignored; there is no queueing. The hazard unit guarantees this does not happen, and the bench checks that it is ignored.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; the write takes effect next cycle.
  - Ignored in RUN or when start=1 (start has priority).
  - hi_we and lo_we together write both registers with wd.
- mult: {hi,lo} = signed a * signed b, full 2*WIDTH product.
- multu: {hi,lo} = unsigned a * unsigned b.
- madd: {hi,lo} = {hi,lo} + signed(a*b). The HI/LO values used are those at commit; they are stable during RUN. Wraps modulo 2^(2*WIDTH).
- msub: {hi,lo} = {hi,lo} - signed(a*b), with the same rules as madd.
- div:
  - lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Overflow case MIN / -1: lo = MIN, hi = 0.
- divu: lo = a/b, hi = a%b, unsigned.
- Divide by zero (div or divu with b==0): the full latency still elapses and busy behaves normally, but HI/LO are left unchanged.
- Results are computed from the latched operands, never from live a/b.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MADD=4, MD_MSUB=5; 6 and 7 are invalid.
  - default latency constants.
  - a function op_is_div.
- One natural sub-module, mdu_calc: combinational and parametrised by WIDTH. It takes the latched op/a/b plus current hi/lo and returns next_hi, next_lo and a write_en signal (0 for divide by zero).
- mdu_pipelined holds the FSM, counter, latches and HI/LO registers.

Test Plan:
- Reset, then mult a=0xFFFFFFFD b=7, start at t:
  - busy=1 in cycles t..t+5, 0 at t+6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB from t+6.
- multu a=0xFFFFFFFD b=7 -> hi=0x00000006, lo=0xFFFFFFEB after 5 cycles.
- div a=0xFFFFFFF9(-7) b=2:
  - After 10 cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload with mtlo wd=0xFFFFFFFF and mthi wd=0, then madd a=1 b=1 -> hi=1, lo=0.
  - Then msub a=1 b=1 -> hi=0, lo=0xFFFFFFFF.
- Divide by zero and ignored writes:
  - hi=0x12, lo=0x34, then divu b=0: busy for 10 cycles, hi/lo still 0x12/0x34 afterwards.
  - mthi issued during RUN is ignored.
  - A second start during RUN is ignored and busy does not extend.
- mult issued, then reset=1 at cycle t+2:
  - busy=0, hi=lo=0 next cycle.
  - No later commit occurs.
  - A fresh divu 100/7 then yields lo=14, hi=2.
